// File: rtl/fib_pkg.sv
// Shared widths and phase naming for the Fibonacci counter.
package fib_pkg;
    localparam int unsigned VAL_W = 32;
    localparam int unsigned IDX_W = 6;

    typedef enum logic {
        CALC = 1'b0,
        DONE = 1'b1
    } phase_e;
endpackage

// File: rtl/fib_step.sv
// Combinational Fibonacci step: next term and carry out of the 32-bit add.
module fib_step
    import fib_pkg::*;
(
    input  logic [VAL_W-1:0] a,
    input  logic [VAL_W-1:0] b,
    output logic [VAL_W-1:0] next_b,
    output logic             carry
);
    assign {carry, next_b} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/fibonacci_counter.sv
// Iterative Fibonacci generator: one term per clock up to the index latched at reset.
module fibonacci_counter
    import fib_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] n,
    output logic [VAL_W-1:0] out,
    output logic [IDX_W-1:0] counter,
    output logic             done,
    output logic             overflow
);
    logic [IDX_W-1:0] n_lat_q, n_lat_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [VAL_W-1:0] a_q, a_d;
    logic [VAL_W-1:0] b_q, b_d;
    logic             b_ovf_q, b_ovf_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [VAL_W-1:0] sum;
    logic             carry;
    phase_e           phase;

    fib_step u_step (
        .a      (a_q),
        .b      (b_q),
        .next_b (sum),
        .carry  (carry)
    );

    // b_ovf tracks wrap of the look-ahead term; it reaches ovf when that term moves into a.
    always_comb begin
        phase   = (cnt_q == n_lat_q) ? DONE : CALC;
        n_lat_d = n_lat_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        b_ovf_d = b_ovf_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (phase == CALC) begin
            a_d     = b_q;
            b_d     = sum;
            cnt_d   = cnt_q + IDX_W'(1);
            b_ovf_d = b_ovf_q | carry;
            ovf_d   = ovf_q | b_ovf_q;
        end else begin
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_lat_q <= n;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= VAL_W'(1);
            b_ovf_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            n_lat_q <= n_lat_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            b_ovf_q <= b_ovf_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign out      = a_q;
    assign counter  = cnt_q;
    assign done     = done_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_fibonacci_counter.sv
// Self-checking bench: exact 64-bit Fibonacci table as reference, directed plus random runs.
module tb_fibonacci_counter;
    logic        clk;
    logic        rst;
    logic [5:0]  n_in;
    logic [31:0] out_w;
    logic [5:0]  counter_w;
    logic        done_w;
    logic        ovf_w;

    int checks;
    int errors;
    longint unsigned fib [0:63];

    fibonacci_counter dut (
        .clk      (clk),
        .rst      (rst),
        .n        (n_in),
        .out      (out_w),
        .counter  (counter_w),
        .done     (done_w),
        .overflow (ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic apply_reset(input int nv, input int cycles);
        rst  = 1'b1;
        n_in = 6'(nv);
        repeat (cycles) @(posedge clk);
        #1;
        chk("rst_out", 64'(out_w), 64'd0);
        chk("rst_cnt", 64'(counter_w), 64'd0);
        chk("rst_done", 64'(done_w), 64'd0);
        chk("rst_ovf", 64'(ovf_w), 64'd0);
    endtask

    // Edges are numbered from the first non-reset edge after release.
    task automatic run_edges(input int nv, input int from_e, input int to_e,
                             input int mid_e, input int mid_n);
        int k;
        rst = 1'b0;
        for (int e = from_e; e <= to_e; e++) begin
            if (e == mid_e) n_in = 6'(mid_n);
            @(posedge clk);
            #1;
            k = (e < nv) ? e : nv;
            chk("out", 64'(out_w), fib[k] & 64'hFFFF_FFFF);
            chk("counter", 64'(counter_w), 64'(k));
            chk("done", 64'(done_w), 64'(e > nv));
            chk("overflow", 64'(ovf_w), 64'(fib[k] >= 64'h1_0000_0000));
        end
    endtask

    initial begin
        int nv;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        n_in   = '0;
        fib[0] = 0;
        fib[1] = 1;
        for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];

        apply_reset(0, 2);
        run_edges(0, 1, 25, -1, 0);

        for (int t = 1; t <= 3; t++) begin
            apply_reset(t, 2);
            run_edges(t, 1, t + 2, -1, 0);
        end

        apply_reset(21, 2);
        run_edges(21, 1, 23, 5, 5);
        chk("f21_const", 64'(out_w), 64'd10946);

        apply_reset(45, 2);
        run_edges(45, 1, 46, -1, 0);
        chk("f45_const", 64'(out_w), 64'd1134903170);

        apply_reset(47, 2);
        run_edges(47, 1, 49, -1, 0);
        chk("f47_const", 64'(out_w), 64'd2971215073);
        chk("f47_noovf", 64'(ovf_w), 64'd0);

        apply_reset(48, 2);
        run_edges(48, 1, 50, -1, 0);
        chk("f48_const", 64'(out_w), 64'd512559680);
        chk("f48_ovf", 64'(ovf_w), 64'd1);

        apply_reset(63, 2);
        run_edges(63, 1, 66, -1, 0);
        chk("f63_cnt", 64'(counter_w), 64'd63);

        // Abort a run at edge 10, restart with n=3.
        apply_reset(45, 2);
        run_edges(45, 1, 9, -1, 0);
        apply_reset(3, 1);
        run_edges(3, 1, 5, -1, 0);

        repeat (12) begin
            nv = int'($urandom_range(0, 63));
            apply_reset(nv, int'($urandom_range(1, 3)));
            run_edges(nv, 1, nv + 3, int'($urandom_range(1, 64)), int'($urandom_range(0, 63)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fibonacci_counter.md
FIBONACCI_COUNTER -- requirements
Module: fibonacci_counter

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset; also the load/start strobe.
REQ-004 n  input  6  requested sequence index, unsigned 0..63.
REQ-005 out  output  32  current Fibonacci value F(k), registered.
REQ-006 counter  output  6  current index k of out, registered.
REQ-007 done  output  1  high when out = F(n_lat) is final, registered.
REQ-008 overflow  output  1  sticky; high when out has wrapped modulo 2^32, registered.

Function
REQ-009 SHALL define F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2), with all arithmetic modulo 2^32.
REQ-010 SHALL hold internal registers: n_lat[5:0], cnt[5:0], a[31:0] (drives out), b[31:0] = F(cnt+1), b_ovf, ovf, done.
REQ-011 SHALL have two phases: CALC (cnt != n_lat) and DONE (cnt == n_lat); the phase is derived from cnt and n_lat, so no separate state register is needed.
REQ-012 On each non-reset edge in CALC: a<=b, b<=a+b (truncated to 32 bits), cnt<=cnt+1, b_ovf<=b_ovf|carry_out(a+b), ovf<=ovf|b_ovf.
REQ-013 On each non-reset edge in DONE: a, b, cnt, ovf and b_ovf hold, and done<=1.
REQ-014 done SHALL be registered as (cnt==n_lat) sampled on non-reset edges.
REQ-015 Latency: out=F(n) and counter=n after exactly n non-reset edges; done rises on edge n+1.
REQ-016 Before completion, out shows the intermediate values F(1), F(2), ... one per edge.
REQ-017 n SHALL be captured only while rst=1; changes to n during CALC/DONE are ignored until the next reset.
REQ-018 n=0: out stays 0, counter stays 0, done=1 after the first non-reset edge.
REQ-019 n=1: out=1 after edge 1; n=2: out=1 after edge 2.
REQ-020 n<=47: result exact and overflow=0 (F(47)=2971215073).
REQ-021 n>=48: out wraps modulo 2^32 and overflow=1 from the edge on which the wrapped value reaches out, then stays set.
REQ-022 cnt SHALL never exceed n_lat, so there is no counter wrap even for n=63.
REQ-023 Reset asserted mid-calculation SHALL abort the calculation and restart from the new n on release.

Reset
REQ-024 On every edge with rst=1: n_lat<=n, cnt<=0, a<=0, b<=1, b_ovf<=0, ovf<=0, done<=0.
REQ-025 Thus during and just after reset: out=0, counter=0, done=0, overflow=0.
REQ-026 SHALL have no asynchronous reset path and no reliance on initial values.

Structure
REQ-027 A shared package fib_pkg SHALL hold the constants VAL_W=32 and IDX_W=6, plus the phase enum {CALC, DONE} used for debug and naming.
REQ-028 An optional sub-module fib_step SHALL be purely combinational: inputs a and b; outputs next_b=a+b and carry. All registers stay in fibonacci_counter.
REQ-029 Outputs SHALL be driven directly from registers, with no combinational path from n or rst to any output.

Verification
REQ-030 rst high 2 cycles with n=0, then release, wait 25 cycles -> out=0, counter=0, done=1 from edge 1, overflow=0.
REQ-031 n=1, then n=2, then n=3 (each preceded by reset) -> out=1, 1, 2 respectively at edge n; done rises at edge n+1.
REQ-032 n=21, release, then drive n=5 mid-run -> out=10946, counter=21 by edge 21; the n change has no effect.
REQ-033 n=45 -> out=1134903170 at edge 45; n=47 -> out=2971215073 with overflow=0.
REQ-034 n=48 -> out=512559680, overflow=1, done=1; n=63 -> counter=63 with no counter wrap.
REQ-035 Reset at edge 10 during n=45, then release with n=3 -> out=0 during reset, then out=2, done=1 at edge 4.
